// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
//   Captures the digits shown on a multiplexed, active-low 4-digit
//   7-segment display and republishes them as a decoded BCD frame.
//
//   Each scanned digit must hold a stable, single-anode pattern for
//   STABLE_CYCLES synchronized samples before it is accepted. When all four
//   digits have been accepted, the frame is published and frame_valid
//   pulses for one cycle.
//
// Parameters
//   STABLE_CYCLES  consecutive identical valid samples to accept (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   seg_n[6:0]   active-low segments, bit6=a ... bit0=g
//   an_n[3:0]    active-low anodes, bit k selects digit k
//   bcd_out[15:0] published frame, digit k at [4k+3:4k]
//   blank[3:0]   digit k was all segments off (stored as 0)
//   err[3:0]     digit k was not a decodable pattern (stored as F)
//   frame_valid  one-cycle pulse after a frame is published
//
// Configuration
//   SEG7_HEX_EN  when defined, also decode the A..F glyphs

module seg7_scan_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg_n,
    input  logic [3:0]  an_n,
    output logic [15:0] bcd_out,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame_valid
);

    localparam logic [7:0] SC = 8'(STABLE_CYCLES);

    // {an_n, seg_n} through a two-flop synchronizer
    logic [10:0] sync1;
    logic [10:0] sync2;
    logic [10:0] last_s;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;

    logic        valid;
    logic [1:0]  idx;
    logic        s_changed;
    logic        accept;

    logic [3:0]  dec_val;
    logic        dec_blank;
    logic        dec_err;

    // Per-digit storage for the frame being assembled
    logic [15:0] slot_val;
    logic [3:0]  slot_blank;
    logic [3:0]  slot_err;
    logic [3:0]  seen;

    // Storage with the incoming digit merged in
    logic [15:0] val_m;
    logic [3:0]  blank_m;
    logic [3:0]  err_m;
    logic [3:0]  seen_m;

    // Exactly one active anode makes a usable sample
    always_comb begin
        valid = 1'b1;
        idx   = 2'd0;
        case (sync2[10:7])
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: valid = 1'b0;
        endcase
    end

    always_comb begin
        dec_val   = 4'hF;
        dec_blank = 1'b0;
        dec_err   = 1'b0;
        case (sync2[6:0])
            7'b0000001: dec_val = 4'h0;
            7'b1001111: dec_val = 4'h1;
            7'b0010010: dec_val = 4'h2;
            7'b0000110: dec_val = 4'h3;
            7'b1001100: dec_val = 4'h4;
            7'b0100100: dec_val = 4'h5;
            7'b0100000: dec_val = 4'h6;
            7'b0001111: dec_val = 4'h7;
            7'b0000000: dec_val = 4'h8;
            7'b0000100: dec_val = 4'h9;
`ifdef SEG7_HEX_EN
            7'b0001000: dec_val = 4'hA;
            7'b1100000: dec_val = 4'hB;
            7'b0110001: dec_val = 4'hC;
            7'b1000010: dec_val = 4'hD;
            7'b0110000: dec_val = 4'hE;
            7'b0111000: dec_val = 4'hF;
`endif
            7'b1111111: begin
                dec_val   = 4'h0;
                dec_blank = 1'b1;
            end
            default: begin
                dec_val = 4'hF;
                dec_err = 1'b1;
            end
        endcase
    end

    // Counter restarts at 1 whenever the sample differs from the previous
    // edge's sample; acceptance fires only on the transition into SC, so
    // with SC=1 a changed sample still accepts even though cnt already is 1.
    assign s_changed = (sync2 != last_s);

    always_comb begin
        if (!valid)
            cnt_nxt = '0;
        else if (s_changed)
            cnt_nxt = 8'd1;
        else if (cnt < SC)
            cnt_nxt = cnt + 8'd1;
        else
            cnt_nxt = cnt;
    end

    assign accept = valid && (cnt_nxt == SC) && (s_changed || (cnt != SC));

    always_comb begin
        val_m   = slot_val;
        blank_m = slot_blank;
        err_m   = slot_err;
        seen_m  = seen;
        val_m[{idx, 2'b00} +: 4] = dec_val;
        blank_m[idx]             = dec_blank;
        err_m[idx]               = dec_err;
        seen_m[idx]              = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1       <= '0;
            sync2       <= '0;
            last_s      <= '0;
            cnt         <= '0;
            slot_val    <= '0;
            slot_blank  <= '0;
            slot_err    <= '0;
            seen        <= '0;
            bcd_out     <= '0;
            blank       <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
        end else begin
            sync1       <= {an_n, seg_n};
            sync2       <= sync1;
            last_s      <= sync2;
            cnt         <= cnt_nxt;
            frame_valid <= 1'b0;
            if (accept) begin
                slot_val   <= val_m;
                slot_blank <= blank_m;
                slot_err   <= err_m;
                if (seen_m == 4'b1111) begin
                    // Publish uses the merged view so the completing digit
                    // appears in the same frame.
                    bcd_out     <= val_m;
                    blank       <= blank_m;
                    err         <= err_m;
                    seen        <= '0;
                    frame_valid <= 1'b1;
                end else begin
                    seen <= seen_m;
                end
            end
        end
    end

endmodule
